// File: rtl/uart_pkg.sv
// Shared UART constants and scheduler state encoding.
// Frame timing derives from clock and baud rate the same way the uart_tx divider does.
package uart_pkg;

  localparam int SYSCLK         = 50000000;
  localparam int UART_BAUD_RATE = 115200;

  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // One idle bit of margin on top of start + 8 data + stop.
  function automatic int calc_frame_cycles(input int clk_hz, input int baud);
    return 11 * (calc_baud_div(clk_hz, baud) + 1);
  endfunction

  localparam int BAUD_DIV     = calc_baud_div(SYSCLK, UART_BAUD_RATE);
  localparam int FRAME_CYCLES = calc_frame_cycles(SYSCLK, UART_BAUD_RATE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational requester arbiter: round-robin after the last grant by default,
// lowest-index fixed priority when UART_TX_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    idx   = '0;
    grant = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    grant[idx] = |req;
  end
`else
  always_comb begin
    logic found;
    int   j;
    idx   = '0;
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    grant[idx] = found;
  end
`endif

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx serializer among NUM_REQ byte producers; a grant loads the
// serializer and then blocks further grants for one frame. Option: UART_TX_SCHED_FIXED_PRIO_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLK_HZ  = SYSCLK,
  parameter int BAUD    = UART_BAUD_RATE,
  localparam int IW           = $clog2(NUM_REQ),
  localparam int BAUD_DIV_L   = calc_baud_div(CLK_HZ, BAUD),
  localparam int FRAME_CYC_L  = 11 * (BAUD_DIV_L + 1),
  localparam int CW           = $clog2(FRAME_CYC_L) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             tx_data,
  output logic                   tx_wr_n,
  output logic                   busy,
  output logic [IW-1:0]          owner
);

  sched_state_e         state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        last;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        win;
  logic                 take;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (win)
  );

  assign take = (state == IDLE) && (|grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= IW'(NUM_REQ - 1);
      owner   <= '0;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      if (take) begin
        tx_data <= req_data[int'(win)*8 +: 8];
        owner   <= win;
        last    <= win;
      end
      if (state == GRANT)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    tx_wr_n   = 1'b1;
    busy      = 1'b0;
    case (state)
      IDLE:  if (take) state_nxt = GRANT;
      GRANT: begin
        ack[owner] = 1'b1;
        tx_wr_n    = 1'b0;
        busy       = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == CW'(FRAME_CYC_L - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized and directed checks of uart_tx_sched against a queue-free arbitration model.
module tb_uart_tx_sched;

  localparam int NR      = 4;
  localparam int FC      = 132;
  localparam int SPACING = FC + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] ack;
  logic [7:0]    tx_data;
  logic          tx_wr_n;
  logic          busy;
  logic [1:0]    owner;

  int checks = 0;
  int errors = 0;
  int last_m = NR - 1;

  uart_tx_sched #(.NUM_REQ(NR), .CLK_HZ(1100), .BAUD(100)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_wr_n  (tx_wr_n),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  // Reference winner: next pending requester after the previous winner in ring order,
  // or simply the lowest pending index in the fixed-priority build.
  function automatic int pick(input logic [NR-1:0] r, input int last);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (r[(last + k) % NR]) return (last + k) % NR;
`endif
    return -1;
  endfunction

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == '0 && cyc < 2000);
  endtask

  task automatic idle_sync();
    req = '0;
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    req      = 4'b1111;
    req_data = $urandom();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0 || tx_wr_n !== 1'b1 || tx_data !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
        errors++;
        $display("FAIL reset ack=%b wr_n=%b data=%h busy=%b owner=%0d, want 0000/1/00/0/0",
                 ack, tx_wr_n, tx_data, busy, owner);
      end
    end
    req     = '0;
    reset_n = 1'b1;
    last_m  = NR - 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc, n;
    logic quiet;
    req = 4'b0100;
    req_data[8*2 +: 8] = 8'hA5;
    wait_ack(cyc);
    checks++;
    if (cyc !== 1 || ack !== 4'b0100 || tx_wr_n !== 1'b0 || tx_data !== 8'hA5 || busy !== 1'b1 || owner !== 2'd2) begin
      errors++;
      $display("FAIL single_grant lat=%0d ack=%b wr_n=%b data=%h owner=%0d, want 1/0100/0/a5/2",
               cyc, ack, tx_wr_n, tx_data, owner);
    end
    req = '0;
    last_m = 2;
    n = 1;
    quiet = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (ack !== '0 || tx_wr_n !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (n !== FC + 1) begin
      errors++;
      $display("FAIL single_busy_len got %0d want %0d", n, FC + 1);
    end
    checks++;
    if (!quiet || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_wait_quiet quiet=%b data=%h, want 1/a5", quiet, tx_data);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    req = 4'b0100;
    req_data[8*2 +: 8] = 8'h5A;
    wait_ack(cyc);
    req = '0;
    // Counter reads 50 on the 51st cycle after the grant cycle.
    repeat (51) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0 || tx_wr_n !== 1'b1 || tx_data !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset ack=%b wr_n=%b data=%h busy=%b owner=%0d, want idle values",
               ack, tx_wr_n, tx_data, busy, owner);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_m  = NR - 1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc, w;
    for (int i = 0; i < NR; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(cyc);
      w = pick(req, last_m);
      last_m = w;
      checks++;
      if (ack !== 4'(1 << w) || tx_wr_n !== 1'b0 || tx_data !== 8'(8'h10 + w) || owner !== 2'(w)) begin
        errors++;
        $display("FAIL rr_grant%0d ack=%b data=%h owner=%0d, want ack=%b data=%h",
                 g, ack, tx_data, owner, 4'(1 << w), 8'(8'h10 + w));
      end
      if (g > 0) begin
        checks++;
        if (cyc !== SPACING) begin
          errors++;
          $display("FAIL rr_spacing%0d got %0d want %0d", g, cyc, SPACING);
        end
      end
    end
    idle_sync();
  endtask

  task automatic test_wrap();
    int cyc, w;
    logic [NR-1:0] pat [3];
    pat[0] = 4'b1000; pat[1] = 4'b1001; pat[2] = 4'b1001;
    req = pat[0];
    for (int g = 0; g < 3; g++) begin
      wait_ack(cyc);
      w = pick(req, last_m);
      last_m = w;
      checks++;
      if (ack !== 4'(1 << w) || owner !== 2'(w) || (g > 0 && cyc !== SPACING)) begin
        errors++;
        $display("FAIL wrap%0d ack=%b owner=%0d gap=%0d, want ack=%b gap=%0d",
                 g, ack, owner, cyc, 4'(1 << w), SPACING);
      end
      if (g < 2) req = pat[g + 1];
    end
    idle_sync();
  endtask

  task automatic test_mid_frame();
    int cyc, w;
    req = 4'b0001;
    wait_ack(cyc);
    last_m = pick(req, last_m);
    req = '0;
    repeat (60) @(negedge clk);
    req = 4'b0010;
    req_data[8*1 +: 8] = 8'hC3;
    wait_ack(cyc);
    w = pick(req, last_m);
    last_m = w;
    checks++;
    if (ack !== 4'b0010 || tx_data !== 8'hC3 || 60 + cyc !== SPACING) begin
      errors++;
      $display("FAIL mid_frame ack=%b data=%h gap=%0d, want 0010/c3/%0d", ack, tx_data, 60 + cyc, SPACING);
    end
    idle_sync();
  endtask

  task automatic test_fixed_pattern();
    int cyc, w;
    req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      wait_ack(cyc);
      w = pick(req, last_m);
      last_m = w;
      checks++;
      if (ack !== 4'(1 << w) || owner !== 2'(w)) begin
        errors++;
        $display("FAIL pattern_1010_%0d ack=%b owner=%0d, want ack=%b", g, ack, owner, 4'(1 << w));
      end
    end
    idle_sync();
  endtask

  task automatic test_back_to_back();
    int cyc, w;
    logic [7:0] exp_data;
    req      = 4'($urandom_range(1, 15));
    req_data = $urandom();
    for (int g = 0; g < 20; g++) begin
      wait_ack(cyc);
      w = pick(req, last_m);
      last_m = w;
      exp_data = req_data[8*w +: 8];
      checks++;
      if (ack !== 4'(1 << w) || tx_data !== exp_data || owner !== 2'(w) || tx_wr_n !== 1'b0 ||
          (g > 0 && cyc !== SPACING)) begin
        errors++;
        $display("FAIL rand%0d req=%b ack=%b data=%h gap=%0d, want ack=%b data=%h gap=%0d",
                 g, req, ack, tx_data, cyc, 4'(1 << w), exp_data, SPACING);
      end
      req      = 4'($urandom_range(1, 15));
      req_data = $urandom();
    end
    idle_sync();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_wait();
    test_round_robin();
    test_wrap();
    test_mid_frame();
    test_fixed_pattern();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
